// File: rtl/sc_spil_fifo_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : sc_regbus_if
//  Purpose  : Register bus carrying one access per cycle. A write is any
//             non-zero byte enable on WENB. A read is RENB=1, and its data
//             returns on RDAT one cycle later.
//  Ports    : ADDR  byte address, bits [11:2] select the register
//             WENB  write byte enables (4)
//             WDAT  write data (32)
//             RENB  read enable
//             RDAT  read data (32), registered in the slave
//             WWAT/WERR/RWAT/RERR  wait/error handshakes (unused, tied 0)
//  Modports : master (bus driver), slave / regif (register block side)
//  Revision : 1.0  initial release
// ============================================================================
interface sc_regbus_if;
    logic [11:0] ADDR;
    logic [3:0]  WENB;
    logic [31:0] WDAT;
    logic        RENB;
    logic [31:0] RDAT;
    logic        WWAT;
    logic        WERR;
    logic        RWAT;
    logic        RERR;

    modport master (
        output ADDR, WENB, WDAT, RENB,
        input  RDAT, WWAT, WERR, RWAT, RERR
    );

    modport slave (
        input  ADDR, WENB, WDAT, RENB,
        output RDAT, WWAT, WERR, RWAT, RERR
    );

    modport regif (
        input  ADDR, WENB, WDAT, RENB,
        output RDAT, WWAT, WERR, RWAT, RERR
    );
endinterface
`default_nettype wire

// File: rtl/sc_spil_fifo_reg.sv
`default_nettype none
// ============================================================================
//  Module   : sc_spil_fifo_reg
//  Purpose  : Register block for the SPI Lite core, with TX and RX word FIFOs.
//             It issues TXSTART with TXDATA for each TX FIFO word and captures
//             RXDATA on SPICOMPLETE. It also provides auto-start streaming,
//             FIFO level thresholds, overflow/underflow status and flush.
//  Ports    : SYSCLK/SYSRSTB  clock and synchronous active-low reset
//             REGBUS          register bus (sc_regbus_if.regif)
//             INTERRUPT       |(IST & IEN)
//             CSSEL/CSEXTEND  chip select index and hold-between-words flag
//             TXSTART/TXDATA  start request and the TX FIFO head word
//             SPIBUSY/SPICOMPLETE/RXDATA  core status and received word
//             BORDER CPOL CPHA CLKDR CSSETUP CSHOLD DWIDTH  format fields
//  Revision : 1.0  initial release
// ============================================================================
module sc_spil_fifo_reg #(
    parameter int NUM_OF_CS    = 32,
    parameter int TXFIFO_DEPTH = 16,
    parameter int RXFIFO_DEPTH = 16
) (
    input  logic        SYSCLK,
    input  logic        SYSRSTB,
    sc_regbus_if.regif  REGBUS,
    output logic        INTERRUPT,
    output logic [4:0]  CSSEL,
    output logic        CSEXTEND,
    output logic        TXSTART,
    input  logic        SPIBUSY,
    input  logic        SPICOMPLETE,
    output logic [31:0] TXDATA,
    input  logic [31:0] RXDATA,
    output logic        BORDER,
    output logic        CPOL,
    output logic        CPHA,
    output logic [7:0]  CLKDR,
    output logic [3:0]  CSSETUP,
    output logic [3:0]  CSHOLD,
    output logic [8:0]  DWIDTH
);

    localparam int TXAW = $clog2(TXFIFO_DEPTH);
    localparam int RXAW = $clog2(RXFIFO_DEPTH);
    localparam int CSW  = (NUM_OF_CS > 1) ? $clog2(NUM_OF_CS) : 0;
    // CSSEL bits above what NUM_OF_CS needs are held at zero.
    localparam logic [4:0]    CS_MASK     = 5'((32'd1 << CSW) - 32'd1);
    localparam logic [TXAW:0] TX_FULL_LVL = (TXAW+1)'(TXFIFO_DEPTH);
    localparam logic [RXAW:0] RX_FULL_LVL = (RXAW+1)'(RXFIFO_DEPTH);
    localparam logic [31:0]   VERSION     = 32'h0002_0000;

    localparam logic [9:0] A_CTRL = 10'h000, A_FMT = 10'h001, A_IST = 10'h002,
                           A_IEN  = 10'h003, A_TXD = 10'h004, A_RXD = 10'h005,
                           A_FST  = 10'h006, A_THR = 10'h007, A_CFG = 10'h008,
                           A_VER  = 10'h009;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RUN = 2'd2} state_t;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    state_t            state_q, state_d;
    logic [8:0]        dwidth_q, dwidth_d;
    logic              csextend_q, csextend_d;
    logic [4:0]        cssel_q, cssel_d;
    logic              txflush_q, txflush_d, rxflush_q, rxflush_d;
    logic [7:0]        clkdr_q, clkdr_d;
    logic [3:0]        cssetup_q, cssetup_d, cshold_q, cshold_d;
    logic              cpha_q, cpha_d, cpol_q, cpol_d, border_q, border_d, auto_q, auto_d;
    logic [5:0]        ien_q, ien_d;
    logic [7:0]        txthr_q, txthr_d, rxthr_q, rxthr_d;
    logic              comp_q, comp_d, txovf_q, txovf_d, rxovf_q, rxovf_d, rxunf_q, rxunf_d;
    logic [31:0]       rdat_q, rdat_d;

    logic [31:0]       tx_mem_q [TXFIFO_DEPTH];
    logic [TXAW-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TXAW:0]     tx_lvl_q, tx_lvl_d;
    logic [31:0]       rx_mem_q [RXFIFO_DEPTH];
    logic [RXAW-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RXAW:0]     rx_lvl_q, rx_lvl_d;

    // ---------------------------------------------------------------- decode
    logic [9:0]  w_addr;
    logic        w_wr, w_rd;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_push, w_tx_pop, w_tx_ovf, w_rx_push, w_rx_pop, w_rx_unf, w_rx_ovf;
    logic        w_start_wr, w_txthr, w_rxthr;
    logic [31:0] w_ctrl_img, w_fmt_img, w_thr_img, w_ist_img, w_fst_img;
    logic [31:0] w_ctrl_m, w_fmt_m, w_thr_m, w_ien_m, w_ist_wv;
    logic [5:0]  w_ist_clr;
    logic        w_unused;

    assign w_addr     = REGBUS.ADDR[11:2];
    assign w_wr       = |REGBUS.WENB;
    assign w_rd       = REGBUS.RENB;

    assign w_tx_full  = (tx_lvl_q == TX_FULL_LVL);
    assign w_tx_empty = (tx_lvl_q == '0);
    assign w_rx_full  = (rx_lvl_q == RX_FULL_LVL);
    assign w_rx_empty = (rx_lvl_q == '0);

    // The word is handed to the core the cycle it acknowledges TXSTART.
    // A pending flush wins over every FIFO operation in its cycle.
    assign w_tx_pop   = (state_q == ST_REQ) && SPIBUSY && !w_tx_empty && !txflush_q;
    assign w_tx_push  = w_wr && (w_addr == A_TXD) && !txflush_q && (!w_tx_full || w_tx_pop);
    assign w_tx_ovf   = w_wr && (w_addr == A_TXD) && !txflush_q && w_tx_full && !w_tx_pop;
    assign w_rx_pop   = w_rd && (w_addr == A_RXD) && !w_rx_empty && !rxflush_q;
    assign w_rx_unf   = w_rd && (w_addr == A_RXD) && w_rx_empty;
    assign w_rx_push  = SPICOMPLETE && !rxflush_q && (!w_rx_full || w_rx_pop);
    assign w_rx_ovf   = SPICOMPLETE && !rxflush_q && w_rx_full && !w_rx_pop;

    assign w_start_wr = w_wr && (w_addr == A_CTRL) && REGBUS.WENB[3] && REGBUS.WDAT[31];
    assign w_txthr    = ({{(7-TXAW){1'b0}}, tx_lvl_q} <= txthr_q);
    assign w_rxthr    = (rxthr_q != 8'd0) && ({{(7-RXAW){1'b0}}, rx_lvl_q} >= rxthr_q);

    assign w_ctrl_img = {11'b0, cssel_q, 3'b0, csextend_q, 3'b0, dwidth_q};
    assign w_fmt_img  = {3'b0, auto_q, 3'b0, border_q, 6'b0, cpol_q, cpha_q,
                         cshold_q, cssetup_q, clkdr_q};
    assign w_thr_img  = {16'b0, rxthr_q, txthr_q};
    assign w_ist_img  = {26'b0, rxunf_q, rxovf_q, txovf_q, w_rxthr, w_txthr, comp_q};
    assign w_fst_img  = {12'b0, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full,
                         {{(7-RXAW){1'b0}}, rx_lvl_q}, {{(7-TXAW){1'b0}}, tx_lvl_q}};

    assign w_ctrl_m   = f_merge(w_ctrl_img, REGBUS.WDAT, REGBUS.WENB);
    assign w_fmt_m    = f_merge(w_fmt_img, REGBUS.WDAT, REGBUS.WENB);
    assign w_thr_m    = f_merge(w_thr_img, REGBUS.WDAT, REGBUS.WENB);
    assign w_ien_m    = f_merge({26'b0, ien_q}, REGBUS.WDAT, REGBUS.WENB);
    assign w_ist_wv   = f_merge(32'b0, REGBUS.WDAT, REGBUS.WENB);
    assign w_ist_clr  = (w_wr && (w_addr == A_IST)) ? w_ist_wv[5:0] : 6'b0;

    assign w_unused   = ^{REGBUS.ADDR[1:0], w_ctrl_m[31:21], w_ctrl_m[15:13], w_ctrl_m[11:9],
                          w_fmt_m[31:29], w_fmt_m[27:25], w_fmt_m[23:18], w_thr_m[31:16],
                          w_ien_m[31:6], w_ist_wv[31:6]};

    // ---------------------------------------------------------------- start FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Auto mode re-arms from IDLE, so queued words stream back to back.
                if ((auto_q && !w_tx_empty && !SPIBUSY && !txflush_q) || (!auto_q && w_start_wr))
                    state_d = ST_REQ;
            end
            ST_REQ:  if (SPIBUSY) state_d = ST_RUN;
            ST_RUN:  if (SPICOMPLETE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FIFO pointers
    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_lvl_d = tx_lvl_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_lvl_d = rx_lvl_q;
        if (txflush_q) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_lvl_d = '0;
        end else begin
            if (w_tx_push) tx_wp_d = tx_wp_q + TXAW'(1);
            if (w_tx_pop)  tx_rp_d = tx_rp_q + TXAW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   tx_lvl_d = tx_lvl_q + (TXAW+1)'(1);
                2'b01:   tx_lvl_d = tx_lvl_q - (TXAW+1)'(1);
                default: tx_lvl_d = tx_lvl_q;
            endcase
        end
        if (rxflush_q) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_lvl_d = '0;
        end else begin
            if (w_rx_push) rx_wp_d = rx_wp_q + RXAW'(1);
            if (w_rx_pop)  rx_rp_d = rx_rp_q + RXAW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   rx_lvl_d = rx_lvl_q + (RXAW+1)'(1);
                2'b01:   rx_lvl_d = rx_lvl_q - (RXAW+1)'(1);
                default: rx_lvl_d = rx_lvl_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- registers
    always_comb begin
        dwidth_d   = dwidth_q;
        csextend_d = csextend_q;
        cssel_d    = cssel_q;
        clkdr_d    = clkdr_q;
        cssetup_d  = cssetup_q;
        cshold_d   = cshold_q;
        cpha_d     = cpha_q;
        cpol_d     = cpol_q;
        border_d   = border_q;
        auto_d     = auto_q;
        ien_d      = ien_q;
        txthr_d    = txthr_q;
        rxthr_d    = rxthr_q;
        // Flush requests last exactly one cycle.
        txflush_d  = 1'b0;
        rxflush_d  = 1'b0;
        if (w_wr) begin
            case (w_addr)
                A_CTRL: begin
                    dwidth_d   = w_ctrl_m[8:0];
                    csextend_d = w_ctrl_m[12];
                    cssel_d    = w_ctrl_m[20:16] & CS_MASK;
                    txflush_d  = REGBUS.WENB[3] & REGBUS.WDAT[30];
                    rxflush_d  = REGBUS.WENB[3] & REGBUS.WDAT[29];
                end
                A_FMT: begin
                    clkdr_d   = w_fmt_m[7:0];
                    cssetup_d = w_fmt_m[11:8];
                    cshold_d  = w_fmt_m[15:12];
                    cpha_d    = w_fmt_m[16];
                    cpol_d    = w_fmt_m[17];
                    border_d  = w_fmt_m[24];
                    auto_d    = w_fmt_m[28];
                end
                A_IEN: ien_d = w_ien_m[5:0];
                A_THR: begin
                    txthr_d = w_thr_m[7:0];
                    rxthr_d = w_thr_m[15:8];
                end
                default: ;
            endcase
        end
        // Hardware set wins over a write-one-to-clear in the same cycle.
        comp_d  = (comp_q  & ~w_ist_clr[0]) | SPICOMPLETE;
        txovf_d = (txovf_q & ~w_ist_clr[3]) | w_tx_ovf;
        rxovf_d = (rxovf_q & ~w_ist_clr[4]) | w_rx_ovf;
        rxunf_d = (rxunf_q & ~w_ist_clr[5]) | w_rx_unf;

        rdat_d = rdat_q;
        if (w_rd) begin
            case (w_addr)
                A_CTRL:  rdat_d = w_ctrl_img | {SPIBUSY, txflush_q, rxflush_q, 29'b0};
                A_FMT:   rdat_d = w_fmt_img;
                A_IST:   rdat_d = w_ist_img;
                A_IEN:   rdat_d = {26'b0, ien_q};
                A_RXD:   rdat_d = w_rx_empty ? 32'h0 : rx_mem_q[rx_rp_q];
                A_FST:   rdat_d = w_fst_img;
                A_THR:   rdat_d = w_thr_img;
                A_CFG:   rdat_d = {8'h00, 8'(RXFIFO_DEPTH), 8'(TXFIFO_DEPTH), 8'(NUM_OF_CS)};
                A_VER:   rdat_d = VERSION;
                default: rdat_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB) begin
            state_q    <= ST_IDLE;
            dwidth_q   <= '0;
            csextend_q <= 1'b0;
            cssel_q    <= '0;
            txflush_q  <= 1'b0;
            rxflush_q  <= 1'b0;
            clkdr_q    <= '0;
            cssetup_q  <= '0;
            cshold_q   <= '0;
            cpha_q     <= 1'b0;
            cpol_q     <= 1'b0;
            border_q   <= 1'b0;
            auto_q     <= 1'b0;
            ien_q      <= '0;
            txthr_q    <= '0;
            rxthr_q    <= '0;
            comp_q     <= 1'b0;
            txovf_q    <= 1'b0;
            rxovf_q    <= 1'b0;
            rxunf_q    <= 1'b0;
            rdat_q     <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_lvl_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_lvl_q   <= '0;
        end else begin
            state_q    <= state_d;
            dwidth_q   <= dwidth_d;
            csextend_q <= csextend_d;
            cssel_q    <= cssel_d;
            txflush_q  <= txflush_d;
            rxflush_q  <= rxflush_d;
            clkdr_q    <= clkdr_d;
            cssetup_q  <= cssetup_d;
            cshold_q   <= cshold_d;
            cpha_q     <= cpha_d;
            cpol_q     <= cpol_d;
            border_q   <= border_d;
            auto_q     <= auto_d;
            ien_q      <= ien_d;
            txthr_q    <= txthr_d;
            rxthr_q    <= rxthr_d;
            comp_q     <= comp_d;
            txovf_q    <= txovf_d;
            rxovf_q    <= rxovf_d;
            rxunf_q    <= rxunf_d;
            rdat_q     <= rdat_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_lvl_q   <= tx_lvl_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_lvl_q   <= rx_lvl_d;
        end
    end

    // FIFO storage needs no reset; the levels qualify every read.
    always_ff @(posedge SYSCLK) begin
        if (w_tx_push) tx_mem_q[tx_wp_q] <= REGBUS.WDAT;
        if (w_rx_push) rx_mem_q[rx_wp_q] <= RXDATA;
    end

    // ---------------------------------------------------------------- outputs
    assign TXSTART     = (state_q == ST_REQ);
    assign TXDATA      = w_tx_empty ? 32'h0 : tx_mem_q[tx_rp_q];
    assign INTERRUPT   = |(w_ist_img[5:0] & ien_q);
    assign CSSEL       = cssel_q;
    assign CSEXTEND    = csextend_q;
    assign DWIDTH      = dwidth_q;
    assign CLKDR       = (clkdr_q < 8'd2) ? 8'd2 : clkdr_q;
    assign CSSETUP     = cssetup_q;
    assign CSHOLD      = cshold_q;
    assign CPHA        = cpha_q;
    assign CPOL        = cpol_q;
    assign BORDER      = border_q;
    assign REGBUS.RDAT = rdat_q;
    assign REGBUS.WWAT = 1'b0;
    assign REGBUS.WERR = 1'b0;
    assign REGBUS.RWAT = 1'b0;
    assign REGBUS.RERR = 1'b0;

endmodule
`default_nettype wire
